// File: rtl/button_debounce_repeat_if.sv
// Interface for one conditioned push-button channel.
// The button side drives the raw level; the conditioner returns the debounced
// level, the press/repeat pulse and the long-press flag.
interface button_debounce_repeat_if;
    logic i_button;
    logic o_button;
    logic o_pressed;
    logic o_long;

    modport master (output i_button, input o_button, o_pressed, o_long);
    modport slave  (input i_button, output o_button, o_pressed, o_long);
endinterface

// File: rtl/button_debounce_repeat.sv
// Push-button conditioner for the lamp-stand light FSM.
// 2-FF synchronizer -> counter debounce -> press FSM (IDLE/PRESS/REPEAT).
// One o_button pulse per press; holding the button past LONG_PRESS_CYCLES
// raises o_long and, when BTN_REPEAT_EN is defined, emits a pulse at the
// long-press point and every REPEAT_CYCLES afterwards.
// With BTN_REPEAT_EN undefined only the initial press pulse is produced.
// Reset i_reset is synchronous and active-low. All outputs are registered.
module button_debounce_repeat #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    button_debounce_repeat_if.slave btn
);
    localparam int SYNC_STAGES = 2;
    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DEB_W-1:0]  DEB_TERM  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] REP_TERM  = HOLD_W'(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

`ifdef BTN_REPEAT_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Synchronizer chain; stage 0 takes the raw pin, later stages the previous one.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = btn.i_button;
            end else begin : g_chain
                assign sync_d[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Debounce state
    logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next, deb_inc;
    logic             stable_reg, stable_next;

    // Press FSM state
    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next, hold_inc;
    logic              long_reg, long_next;
    logic              button_reg, button_next;
    logic              pulse_req;

    // Debounce: count consecutive cycles of disagreement, accept the new level at the terminal count.
    always_comb begin
        deb_cnt_next = '0;
        stable_next  = stable_reg;
        deb_inc      = (deb_cnt_reg == '1) ? deb_cnt_reg : deb_cnt_reg + DEB_ONE;
        if (sync_out != stable_reg) begin
            if (deb_inc == DEB_TERM) begin
                stable_next  = sync_out;
                deb_cnt_next = '0;
            end else begin
                deb_cnt_next = deb_inc;
            end
        end
    end

    // Press FSM: decisions use the level being accepted this cycle so the press pulse lines up with o_pressed.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        long_next  = long_reg;
        pulse_req  = 1'b0;
        hold_inc   = (hold_reg == '1) ? hold_reg : hold_reg + HOLD_ONE;
        if (!stable_next) begin
            // Release always wins, including over a terminal count in the same cycle.
            state_next = ST_IDLE;
            hold_next  = '0;
            long_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    pulse_req  = ~stable_reg;
                    hold_next  = '0;
                    state_next = ST_PRESS;
                end
                ST_PRESS: begin
                    if (hold_inc == LONG_TERM) begin
                        long_next  = 1'b1;
                        pulse_req  = REPEAT_EN;
                        hold_next  = '0;
                        state_next = ST_REPEAT;
                    end else begin
                        hold_next = hold_inc;
                    end
                end
                ST_REPEAT: begin
                    long_next = 1'b1;
                    if (hold_inc == REP_TERM) begin
                        pulse_req = REPEAT_EN;
                        hold_next = '0;
                    end else begin
                        hold_next = hold_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    hold_next  = '0;
                    long_next  = 1'b0;
                end
            endcase
        end
        // Never pulse on two consecutive cycles.
        button_next = pulse_req & ~button_reg;
    end

    // Input synchronizer and debounce registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sync_reg    <= '0;
            deb_cnt_reg <= '0;
            stable_reg  <= 1'b0;
        end else begin
            sync_reg    <= sync_d;
            deb_cnt_reg <= deb_cnt_next;
            stable_reg  <= stable_next;
        end
    end

    // FSM state, hold counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg  <= ST_IDLE;
            hold_reg   <= '0;
            long_reg   <= 1'b0;
            button_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            long_reg   <= long_next;
            button_reg <= button_next;
        end
    end

    assign btn.o_button  = button_reg;
    assign btn.o_pressed = stable_reg;
    assign btn.o_long    = long_reg;

endmodule
